reg_file_rd: RTL and testbench
==============================

Name: reg_file_rd

Overview:
- Architectural register file that consumes the writeback stream produced by the load/writeback block (wr_en_RF, Data_In_RF) and serves operands to the ALU.
- Adds a pending-write scoreboard so issue logic can tell whether an operand is still awaiting its producer.
- Two registered read ports with same-cycle write bypass; sits between the writeback stage and the ALU operand muxes.

Parameters:
DATA_W  32  register width
ADDR_W  5   register index width
NREGS   32  number of registers (x0 hardwired to zero)

Ports:
clk         in   1       clock, all state updates on rising edge
rst         in   1       synchronous reset, active-high
wr_en_RF    in   1       writeback enable from load/writeback block
wr_addr     in   ADDR_W  destination register of writeback
Data_In_RF  in   DATA_W  writeback data
rsv_en      in   1       issue marks rsv_addr as pending
rsv_addr    in   ADDR_W  register being reserved
rd_en       in   1       operand read request
rs1_addr    in   ADDR_W  read port 1 index
rs2_addr    in   ADDR_W  read port 2 index
rs1_data    out  DATA_W  registered read data, port 1
rs2_data    out  DATA_W  registered read data, port 2
rs1_ready   out  1       port 1 operand not pending
rs2_ready   out  1       port 2 operand not pending
rd_valid    out  1       one-cycle pulse: read outputs updated
pend_cnt    out  ADDR_W+1  number of registers currently pending

Behaviour:
- One clock (clk), synchronous active-high reset (rst). At a rising edge with rst=1, all registers and pending bits clear to 0. Outputs go to rs1_data=rs2_data=0, rs1_ready=rs2_ready=1, rd_valid=0 and pend_cnt=0. Reset overrides all same-cycle writes, reserves and reads.
- Write: at an edge with wr_en_RF=1 and wr_addr!=0, regs[wr_addr]<=Data_In_RF and pending[wr_addr]<=0. Writes to x0 are ignored, and x0 always reads 0.
- Reserve: at an edge with rsv_en=1 and rsv_addr!=0, pending[rsv_addr]<=1. A reserve to x0 is ignored.
- Simultaneous write and reserve to the same index: the data is written, and pending ends at 1 because the reserve belongs to the younger producer. To different indices, both take effect.
- Read latency is 1 cycle. At an edge with rd_en=1:
  - rsN_data <= (wr_en_RF && wr_addr==rsN_addr && rsN_addr!=0) ? Data_In_RF : regs[rsN_addr]. This is write-through bypass.
  - rsN_ready <= (rsN_addr==0) || !pending[rsN_addr] || (wr_en_RF && wr_addr==rsN_addr).
  - A same-cycle reservation is not visible to the same-cycle read.
  - rd_valid<=1.
- At an edge with rd_en=0: rsN_data and rsN_ready hold their previous values, and rd_valid<=0.
- rs1_addr==rs2_addr is legal; both ports return identical data and ready.
- pend_cnt tracks the population count of pending bits, updated in the same edge as the bits. Net per-edge change:
  - +1 when a reserve sets a previously clear bit.
  - −1 when a write clears a set bit with no same-index reserve.
  - 0 when a write and a reserve hit the same already-pending index.
  - The count never exceeds NREGS−1.
- Reserving an already-pending register leaves the count unchanged.
- Writing a non-pending register leaves the count unchanged.
- No other state; no combinational path from inputs to outputs.

Test Plan:
1. Reset then read: rst=1 for 2 cycles, then rd_en=1, rs1=5, rs2=0 → next cycle rs1_data=0, rs2_data=0, both ready=1, rd_valid=1, pend_cnt=0.
2. Immediate writeback: wr_en_RF=1, wr_addr=5, Data_In_RF=0x000AAAAA. Next cycle read rs1=5 → rs1_data=0x000AAAAA. A write to x0 of 0xDEADBEEF, then reading rs2=0 → rs2_data=0.
3. Bypass: in the same cycle, write x7=0xDEADBEEF while rd_en=1 with rs1=7, rs2=7 → next cycle both ports read 0xDEADBEEF, rd_valid=1. The following cycle, with rd_en=0 → data held, rd_valid=0.
4. Scoreboard: reserve x3 → pend_cnt=1. Read rs1=3 → rs1_ready=0. Write x3=0x00012345 together with a read of rs1=3 in the same cycle → rs1_ready=1, rs1_data=0x00012345, and pend_cnt=0 after the edge.
5. Collision: x4 pending; in the same cycle write x4=0x11 and reserve x4 → pend_cnt stays 1, regs[4]=0x11, and a later read returns ready=0 with data=0x11. Reserve x0 → pend_cnt unchanged.
6. Reset mid-operation: reserve x1, x2, x9 (pend_cnt=3) and write x1=0x55. Assert rst with rd_en=1 and wr_en_RF=1 in the same cycle → pend_cnt=0, rd_valid=0, and a subsequent read of x1 returns 0 with ready=1.

Source files
------------

// File: rtl/reg_file_rd.sv
// Architectural register file with pending-write scoreboard.
// Two registered read ports with write-through bypass.
module reg_file_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_RF,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] Data_In_RF,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_ready,
  output logic              rs2_ready,
  output logic              rd_valid,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int CW = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DATA_W-1:0] rs1_q, rs1_d;
  logic [DATA_W-1:0] rs2_q, rs2_d;
  logic              rdy1_q, rdy1_d;
  logic              rdy2_q, rdy2_d;
  logic              vld_q, vld_d;

  logic wr_hit;
  logic rsv_hit;
  logic same_idx;
  logic cnt_inc;
  logic cnt_dec;
  logic byp1, byp2;
  logic fwd1, fwd2;

  // Qualify write/reserve: x0 is never written nor reserved.
  always_comb begin
    wr_hit   = wr_en_RF && (wr_addr != '0);
    rsv_hit  = rsv_en && (rsv_addr != '0);
    same_idx = rsv_hit && (rsv_addr == wr_addr);
  end

  // Pending bits: write clears, younger reserve wins on collision.
  always_comb begin
    pend_d = pend_q;
    if (wr_hit)
      pend_d[wr_addr] = 1'b0;
    if (rsv_hit)
      pend_d[rsv_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Population count tracked by per-edge delta.
  always_comb begin
    cnt_inc = rsv_hit && !pend_q[rsv_addr];
    cnt_dec = wr_hit && pend_q[wr_addr] && !same_idx;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (cnt_inc && !cnt_dec): cnt_d = cnt_q + CW'(1);
      (cnt_dec && !cnt_inc): cnt_d = cnt_q - CW'(1);
      default:               cnt_d = cnt_q;
    endcase
  end

  // Read ports: bypass same-cycle writeback, hold when idle.
  always_comb begin
    byp1   = wr_en_RF && (wr_addr == rs1_addr);
    byp2   = wr_en_RF && (wr_addr == rs2_addr);
    fwd1   = byp1 && (rs1_addr != '0);
    fwd2   = byp2 && (rs2_addr != '0);
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    vld_d  = 1'b0;
    if (rd_en) begin
      vld_d = 1'b1;
      unique case (1'b1)
        (rs1_addr == '0): rs1_d = '0;
        fwd1:             rs1_d = Data_In_RF;
        default:          rs1_d = regs_q[rs1_addr];
      endcase
      unique case (1'b1)
        (rs2_addr == '0): rs2_d = '0;
        fwd2:             rs2_d = Data_In_RF;
        default:          rs2_d = regs_q[rs2_addr];
      endcase
      rdy1_d = (rs1_addr == '0) || !pend_q[rs1_addr] || byp1;
      rdy2_d = (rs2_addr == '0) || !pend_q[rs2_addr] || byp2;
    end
  end

  // Register array storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[wr_addr] <= Data_In_RF;
    end
  end

  // Scoreboard state and registered read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rdy1_q <= 1'b1;
      rdy2_q <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
      vld_q  <= vld_d;
    end
  end

  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
  assign rs1_ready = rdy1_q;
  assign rs2_ready = rdy2_q;
  assign rd_valid  = vld_q;
  assign pend_cnt  = cnt_q;

endmodule

// File: tb/tb_reg_file_rd.sv
// Bench for reg_file_rd: directed vector table, then
// random traffic checked against a behavioural model.
module tb_reg_file_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_RF;
  logic [4:0]  wr_addr;
  logic [31:0] Data_In_RF;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rd_en;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_ready;
  logic        rs2_ready;
  logic        rd_valid;
  logic [5:0]  pend_cnt;

  always #5 clk = ~clk;

  reg_file_rd dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_RF   (wr_en_RF),
    .wr_addr    (wr_addr),
    .Data_In_RF (Data_In_RF),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rd_en      (rd_en),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_ready  (rs1_ready),
    .rs2_ready  (rs2_ready),
    .rd_valid   (rd_valid),
    .pend_cnt   (pend_cnt)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        r1;
    logic        r2;
    logic        v;
    logic [5:0]  cnt;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    exp_t        e;
    string       tag;
  } vec_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  exp_t        m_out;

  function automatic void add(
    input string tag,
    input logic r, input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic re, input logic [4:0] ra,
    input logic rd, input logic [4:0] a1, input logic [4:0] a2,
    input logic [31:0] d1, input logic [31:0] d2,
    input logic r1, input logic r2, input logic v,
    input logic [5:0] cnt);
    vec_t x;
    x.tag = tag; x.rst = r; x.we = we; x.wa = wa; x.wd = wd;
    x.re = re; x.ra = ra; x.rd = rd; x.a1 = a1; x.a2 = a2;
    x.e.d1 = d1; x.e.d2 = d2; x.e.r1 = r1; x.e.r2 = r2;
    x.e.v = v; x.e.cnt = cnt;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra,
                       input logic rd, input logic [4:0] a1,
                       input logic [4:0] a2);
    @(negedge clk);
    rst = r; wr_en_RF = we; wr_addr = wa; Data_In_RF = wd;
    rsv_en = re; rsv_addr = ra; rd_en = rd;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic sample(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " rs1_data"}, rs1_data, e.d1);
      chk({tag, " rs2_data"}, rs2_data, e.d2);
      chk({tag, " rs1_ready"}, 32'(rs1_ready), 32'(e.r1));
      chk({tag, " rs2_ready"}, 32'(rs2_ready), 32'(e.r2));
      chk({tag, " rd_valid"}, 32'(rd_valid), 32'(e.v));
      chk({tag, " pend_cnt"}, 32'(pend_cnt), 32'(e.cnt));
    end
  endtask

  // Behavioural model: returns outputs after one edge.
  function automatic exp_t model(
    input logic r, input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic re, input logic [4:0] ra,
    input logic rd, input logic [4:0] a1, input logic [4:0] a2);
    exp_t o;
    o = m_out;
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_pend = 0;
      o.d1 = 0; o.d2 = 0; o.r1 = 1; o.r2 = 1; o.v = 0;
    end else begin
      o.v = rd;
      if (rd) begin
        if (a1 == 0) o.d1 = 0;
        else if (we && wa == a1) o.d1 = wd;
        else o.d1 = m_regs[a1];
        if (a2 == 0) o.d2 = 0;
        else if (we && wa == a2) o.d2 = wd;
        else o.d2 = m_regs[a2];
        o.r1 = (a1 == 0) || !m_pend[a1] || (we && wa == a1);
        o.r2 = (a2 == 0) || !m_pend[a2] || (we && wa == a2);
      end
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (re && ra != 0) m_pend[ra] = 1'b1;
    end
    o.cnt = 6'($countones(m_pend));
    m_out = o;
    return o;
  endfunction

  initial begin
    rst = 1; wr_en_RF = 0; wr_addr = 0; Data_In_RF = 0;
    rsv_en = 0; rsv_addr = 0; rd_en = 0; rs1_addr = 0; rs2_addr = 0;

    // tag rst we wa wd re ra rd a1 a2 | d1 d2 r1 r2 v cnt
    add("rst0",   1,0,0,0,          0,0,0,0,0, 0,0,1,1,0,0);
    add("rst1",   1,0,0,0,          0,0,0,0,0, 0,0,1,1,0,0);
    add("rdrst",  0,0,0,0,          0,0,1,5,0, 0,0,1,1,1,0);
    add("wr5",    0,1,5,32'h000AAAAA,0,0,0,0,0, 0,0,1,1,0,0);
    add("rd5x0",  0,1,0,32'hDEADBEEF,0,0,1,5,0,
        32'h000AAAAA,0,1,1,1,0);
    add("byp7",   0,1,7,32'hDEADBEEF,0,0,1,7,7,
        32'hDEADBEEF,32'hDEADBEEF,1,1,1,0);
    add("hold",   0,0,0,0,          0,0,0,0,0,
        32'hDEADBEEF,32'hDEADBEEF,1,1,0,0);
    add("rsv3",   0,0,0,0,          1,3,0,0,0,
        32'hDEADBEEF,32'hDEADBEEF,1,1,0,1);
    add("rd3p",   0,0,0,0,          0,0,1,3,5,
        0,32'h000AAAAA,0,1,1,1);
    add("wr3byp", 0,1,3,32'h00012345,0,0,1,3,7,
        32'h00012345,32'hDEADBEEF,1,1,1,0);
    add("rsv4",   0,0,0,0,          1,4,0,0,0,
        32'h00012345,32'hDEADBEEF,1,1,0,1);
    add("coll4",  0,1,4,32'h11,     1,4,0,0,0,
        32'h00012345,32'hDEADBEEF,1,1,0,1);
    add("rd4",    0,0,0,0,          0,0,1,4,4,
        32'h11,32'h11,0,0,1,1);
    add("rsvx0",  0,0,0,0,          1,0,0,0,0,
        32'h11,32'h11,0,0,0,1);
    add("rsv9rd", 0,0,0,0,          1,9,1,9,4,
        0,32'h11,1,0,1,2);
    add("nopend", 0,1,10,32'h77,    1,4,0,0,0,
        0,32'h11,1,0,0,2);
    add("rsv1",   0,0,0,0,          1,1,0,0,0,
        0,32'h11,1,0,0,3);
    add("rsv2wr1",0,1,1,32'h55,     1,2,0,0,0,
        0,32'h11,1,0,0,3);
    add("rd1_10", 0,0,0,0,          0,0,1,1,10,
        32'h55,32'h77,1,1,1,3);
    add("midrst", 1,1,1,32'h99,     1,5,1,1,0,
        0,0,1,1,0,0);
    add("rdpost", 0,0,0,0,          0,0,1,1,4,
        0,0,1,1,1,0);
    add("wrrsv2", 0,1,2,32'hCAFE,   1,2,1,2,2,
        32'hCAFE,32'hCAFE,1,1,1,1);
    add("rd2p",   0,0,0,0,          0,0,1,2,0,
        32'hCAFE,0,0,1,1,1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].re, vecs[i].ra, vecs[i].rd,
            vecs[i].a1, vecs[i].a2);
      sb.push_back(vecs[i].e);
      sample(vecs[i].tag);
    end

    // Random traffic: reserve-heavy to push count to its ceiling.
    m_out.d1 = 0; m_out.d2 = 0; m_out.r1 = 1;
    m_out.r2 = 1; m_out.v = 0; m_out.cnt = 0;
    begin
      exp_t e;
      logic r, we, re, rd;
      logic [4:0] wa, ra, a1, a2;
      logic [31:0] wd;
      e = model(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      sb.push_back(e);
      sample("rnd_rst");
      for (int n = 0; n < 400; n++) begin
        r  = ($urandom_range(0, 99) == 0);
        we = (n < 150) ? ($urandom_range(0, 9) == 0)
                       : $urandom_range(0, 1) == 1;
        re = $urandom_range(0, 2) != 0;
        rd = $urandom_range(0, 3) != 0;
        wa = 5'($urandom_range(0, 31));
        ra = 5'($urandom_range(0, 31));
        a1 = 5'($urandom_range(0, 31));
        a2 = ($urandom_range(0, 4) == 0) ? a1
                                         : 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) a1 = wa;
        if ($urandom_range(0, 5) == 0) ra = wa;
        wd = $urandom;
        e = model(r, we, wa, wd, re, ra, rd, a1, a2);
        drive(r, we, wa, wd, re, ra, rd, a1, a2);
        sb.push_back(e);
        sample("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
